// File: rtl/udc_event_logger.sv
// udc_event_logger
//   Watches the status outputs of the up/down counter, turns rising edges of
//   ec (end count) and err into timestamped records, and queues them in a
//   FIFO that a host drains through a valid/ready handshake.
//
//   Record layout on evt_data: {ts[TS_W-1:0], cout[CW-1:0], dir, type[1:0]}
//     type 01 = ec edge only, 10 = err edge only, 11 = both in one cycle.
//
// Ports
//   clk        in   system clock, posedge
//   reset      in   synchronous active-high reset; flushes the FIFO
//   cout       in   counter value (CW bits)
//   dir        in   counter direction, 1 = up
//   err        in   counter error flag (level)
//   ec         in   counter end-count flag (level)
//   evt_ready  in   host accepts the head record
//   clr_ovf    in   clears overflow and drop_cnt
//   evt_valid  out  head record available
//   evt_data   out  head record
//   evt_count  out  FIFO occupancy, 0..DEPTH
//   overflow   out  sticky: a record was dropped
//   drop_cnt   out  dropped records, saturating at 255
module udc_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CW-1:0]              cout,
  input  logic                       dir,
  input  logic                       err,
  input  logic                       ec,
  input  logic                       evt_ready,
  input  logic                       clr_ovf,
  output logic                       evt_valid,
  output logic [TS_W+CW+2:0]         evt_data,
  output logic [$clog2(DEPTH):0]     evt_count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int REC_W = TS_W + CW + 3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [TS_W-1:0]  r_ts;
  logic             r_ec_q;
  logic             r_err_q;
  logic [REC_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [REC_W-1:0] r_out;
  logic             r_ovf;
  logic [7:0]       r_drop;

  logic             w_ec_rise;
  logic             w_err_rise;
  logic             w_evt;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;
  logic [AW-1:0]    w_rptr_nxt;
  logic [CNT_W-1:0] w_rem;
  logic [REC_W-1:0] w_head_nxt;

  assign w_ec_rise  = ec & ~r_ec_q;
  assign w_err_rise = err & ~r_err_q;
  assign w_evt      = w_ec_rise | w_err_rise;
  assign w_rec      = {r_ts, cout, dir, w_err_rise, w_ec_rise};

  assign w_full = (r_count == CNT_W'(DEPTH));
  assign w_pop  = (r_count != '0) & evt_ready;
  // A pop on a full FIFO frees the slot the push is about to use.
  assign w_push = w_evt & (~w_full | w_pop);
  assign w_drop = w_evt & w_full & ~w_pop;

  assign w_rptr_nxt = w_pop ? r_rptr + AW'(1) : r_rptr;
  assign w_rem      = w_pop ? r_count - CNT_W'(1) : r_count;

  // The head is held in a register so the output never depends on inputs
  // combinationally. When nothing older survives this cycle, the new record
  // (if any) becomes the head; otherwise the next surviving entry does. The
  // slot being written can never be that surviving entry.
  always_comb begin
    w_head_nxt = r_out;
    if (w_rem == '0) begin
      if (w_push) w_head_nxt = w_rec;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts    <= '0;
      // Reset high so a flag already asserted at release is not an edge.
      r_ec_q  <= 1'b1;
      r_err_q <= 1'b1;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_ts    <= r_ts + TS_W'(1);
      r_ec_q  <= ec;
      r_err_q <= err;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_rptr  <= w_rptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_out <= w_head_nxt;
      // A drop in the same cycle as a clear restarts the count at one.
      if (w_drop) begin
        r_ovf  <= 1'b1;
        r_drop <= clr_ovf ? 8'd1 : sat_inc8(r_drop);
      end else if (clr_ovf) begin
        r_ovf  <= 1'b0;
        r_drop <= '0;
      end
    end
  end

  assign evt_valid = (r_count != '0);
  assign evt_data  = r_out;
  assign evt_count = r_count;
  assign overflow  = r_ovf;
  assign drop_cnt  = r_drop;

endmodule
